// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS run controller: FSM states, fixed sizes
// and the busy/done status encoding.
package mips_ctrl_pkg;

  localparam int RF_WORDS      = 32;
  localparam int CPURST_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CPURST  = 3'd2,
    S_RUN     = 3'd3,
    S_DUMP_RF = 3'd4,
    S_DUMP_DM = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  // {busy, done}
  typedef enum logic [1:0] {
    STAT_IDLE = 2'b00,
    STAT_DONE = 2'b01,
    STAT_BUSY = 2'b10
  } status_e;

  function automatic status_e status_of(input state_e s);
    case (s)
      S_IDLE:  return STAT_IDLE;
      S_DONE:  return STAT_DONE;
      default: return STAT_BUSY;
    endcase
  endfunction

endpackage

// File: rtl/dump_seq.sv
// Result-stream sequencer shared by the register-file and data-memory dump
// phases. sel=0 walks the 32 registers (word 0 forced to zero), sel=1 walks
// the low DUMP_WORDS data-memory words and flags the final one as last.
// The index only moves on a handshake, so the read address and therefore
// the combinational read data stay put while the sink stalls.
module dump_seq
  import mips_ctrl_pkg::*;
#(
  parameter int DUMP_WORDS = 9,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             sel,
  input  logic             dump_ready,
  input  logic [31:0]      rf_rdata,
  input  logic [31:0]      dm_rdata,
  output logic [IDX_W-1:0] idx,
  output logic             dump_valid,
  output logic [31:0]      dump_data,
  output logic             dump_last,
  output logic             phase_end
);

  localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_WORDS - 1);
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DUMP_WORDS - 1);

  logic [IDX_W-1:0] idx_last;
  logic             hs;

  // Stream outputs and end-of-phase detect, all from the registered index.
  always_comb begin
    idx_last   = sel ? DM_LAST : RF_LAST;
    hs         = active & dump_ready;
    phase_end  = hs & (idx == idx_last);
    dump_valid = active;
    dump_last  = active & sel & (idx == DM_LAST);
    dump_data  = '0;
    if (active) begin
      if (sel)             dump_data = dm_rdata;
      else if (idx != '0)  dump_data = rf_rdata;
    end
  end

  // Index advances per accepted word and rewinds at each phase boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          idx <= '0;
    else if (!active)    idx <= '0;
    else if (phase_end)  idx <= '0;
    else if (hs)         idx <= idx + 1'b1;
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Sequencing controller for the single-cycle MIPS core: program load,
// core reset pulse, counted run, then register-file and data-memory dump.
// Optional build macro RUN_TRACE_EN adds a registered PC/instruction trace
// of every enabled run cycle.
//
// state     | meaning
// S_IDLE    | waiting for start, core held in reset
// S_LOAD    | accepting program words into instruction memory
// S_CPURST  | core reset pulse, CPURST_CYCLES long
// S_RUN     | core clock enabled while the run counter is nonzero
// S_DUMP_RF | streaming register file, word 0 forced to zero
// S_DUMP_DM | streaming low data-memory words, last flagged
// S_DONE    | results delivered, waiting for next start
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int IM_AW      = 10,
  parameter int DUMP_WORDS = 9,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             cpu_clk_en,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic [29:0]      dm_raddr,
  input  logic [31:0]      dm_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [31:0]      dump_data,
  output logic             dump_last,
  output logic             busy,
  output logic             done
`ifdef RUN_TRACE_EN
  ,
  input  logic [31:0]      cpu_pc,
  input  logic [31:0]      cpu_instr,
  output logic             tr_valid,
  output logic [31:0]      tr_pc,
  output logic [31:0]      tr_instr
`endif
);

  localparam int IDX_W = $clog2((DUMP_WORDS > RF_WORDS) ? DUMP_WORDS : RF_WORDS);
  localparam int RC_W  = $clog2(CPURST_CYCLES + 1);

  state_e           state, state_nxt;
  logic [IM_AW-1:0] ld_addr;
  logic [CNT_W-1:0] run_cnt;
  logic [RC_W-1:0]  rst_cnt;
  logic             start_ok, ld_hs, ld_end;
  logic             dump_active, dump_sel, phase_end;
  logic [IDX_W-1:0] dump_idx;

  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE));
  assign ld_hs    = ld_valid & (state == S_LOAD);
  // Loading stops on the tagged last word or when memory is full.
  assign ld_end   = ld_hs & (ld_last | (ld_addr == '1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; a zero run count skips RUN entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_LOAD;
      S_LOAD:         if (ld_end) state_nxt = S_CPURST;
      S_CPURST:       if (rst_cnt == '0) state_nxt = (run_cnt == '0) ? S_DUMP_RF : S_RUN;
      S_RUN:          if (run_cnt <= CNT_W'(1)) state_nxt = S_DUMP_RF;
      S_DUMP_RF:      if (phase_end) state_nxt = S_DUMP_DM;
      S_DUMP_DM:      if (phase_end) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state and counters.
  always_comb begin
    ld_ready    = (state == S_LOAD);
    im_we       = ld_hs;
    im_addr     = ld_addr;
    im_wdata    = ld_hs ? ld_data : '0;
    cpu_rst     = (state == S_IDLE) | (state == S_LOAD) | (state == S_CPURST);
    cpu_clk_en  = (state == S_RUN) & (run_cnt != '0);
    dump_active = (state == S_DUMP_RF) | (state == S_DUMP_DM);
    dump_sel    = (state == S_DUMP_DM);
    rf_raddr    = (state == S_DUMP_RF) ? dump_idx[4:0] : 5'd0;
    dm_raddr    = (state == S_DUMP_DM) ? {{(30 - IDX_W){1'b0}}, dump_idx} : 30'd0;
    {busy, done} = status_of(state);
  end

  // Load address, core-reset down-counter and run down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_addr <= '0;
      run_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      if (start_ok) begin
        ld_addr <= '0;
        run_cnt <= run_cycles;
      end else if (ld_hs) begin
        ld_addr <= ld_addr + 1'b1;
      end
      if (ld_end)                               rst_cnt <= RC_W'(CPURST_CYCLES - 1);
      else if (state == S_CPURST && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
      if (cpu_clk_en) run_cnt <= run_cnt - 1'b1;
    end
  end

  dump_seq #(
    .DUMP_WORDS (DUMP_WORDS),
    .IDX_W      (IDX_W)
  ) u_dump_seq (
    .clk        (clk),
    .rst_n      (rst),
    .active     (dump_active),
    .sel        (dump_sel),
    .dump_ready (dump_ready),
    .rf_rdata   (rf_rdata),
    .dm_rdata   (dm_rdata),
    .idx        (dump_idx),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .phase_end  (phase_end)
  );

`ifdef RUN_TRACE_EN
  // Capture PC/instruction of each enabled core cycle, visible one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tr_valid <= 1'b0;
      tr_pc    <= '0;
      tr_instr <= '0;
    end else begin
      tr_valid <= cpu_clk_en;
      if (cpu_clk_en) begin
        tr_pc    <= cpu_pc;
        tr_instr <= cpu_instr;
      end
    end
  end
`endif

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Sequencing controller for the single-cycle MIPS core. It loads instruction memory from a host word stream, then pulses the CPU reset and runs the core for a programmed number of clock-enabled cycles. It then freezes the core and streams out the register file followed by the low data-memory words. It replaces testbench-side `$readmemh`/cycle-count/dump sequencing with synthesizable hardware and sits between the host link and the CPU top.

## Interface
- `IM_AW`, 10, instruction-memory word-address width
- `DUMP_WORDS`, 9, data-memory words dumped (word 0 upward)
- `CNT_W`, 16, run-cycle counter width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle start pulse; honoured only in IDLE or DONE
- `run_cycles` in CNT_W: CPU cycles to execute; sampled on accepted `start`
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 32, `ld_last` in 1: program load stream
- `im_we` out 1, `im_addr` out IM_AW, `im_wdata` out 32: instruction-memory write port
- `cpu_rst` out 1: active-high reset to the core
- `cpu_clk_en` out 1: core clock enable
- `rf_raddr` out 5, `rf_rdata` in 32: register-file debug read port, combinational read
- `dm_raddr` out 30, `dm_rdata` in 32: data-memory debug word read, combinational read
- `dump_valid` out 1, `dump_ready` in 1, `dump_data` out 32, `dump_last` out 1: result stream
- `busy` out 1, `done` out 1: status

## Operation
- States: IDLE → LOAD → CPURST → RUN → DUMP_RF → DUMP_DM → DONE.
- IDLE / DONE:
  - `start` latches `run_cycles`, clears the load address, and goes to LOAD.
  - `done`=1 only in DONE.
- LOAD:
  - `ld_ready`=1. Each handshake asserts `im_we` combinationally in that cycle, with `im_wdata`=`ld_data` and `im_addr`=load counter, then increments the counter.
  - A handshake with `ld_last`, or the write to address 2^IM_AW−1, goes to CPURST. Further words are not accepted.
- CPURST: `cpu_rst`=1 for exactly 2 cycles, then RUN.
- RUN:
  - `cpu_rst`=0, `cpu_clk_en`=1 while the down-counter is nonzero. Entry with a count of 0 goes directly to DUMP_RF.
  - Exactly `run_cycles` enabled core edges occur.
- DUMP_RF:
  - `cpu_clk_en`=0. Index i = 0..31, `rf_raddr`=i, `dump_data`=`rf_rdata`. Word 0 is forced to 0.
  - `dump_valid`=1 and the data is held stable until `dump_ready`. The index advances on handshake.
- DUMP_DM:
  - Same rules with `dm_raddr`=j, j = 0..DUMP_WORDS−1.
  - `dump_last`=1 on the final word. That handshake goes to DONE.
- Outputs by state:
  - `cpu_rst`=1 in IDLE, LOAD and CPURST; 0 otherwise.
  - `busy`=1 in LOAD through DUMP_DM.
- `start` in a busy state is ignored.
- Reset: async assertion forces IDLE from any state, including mid-load and mid-dump. All counters are cleared. Reset values:
  - `cpu_rst`=1
  - `cpu_clk_en`=0, `ld_ready`=0, `im_we`=0
  - `dump_valid`=0, `dump_last`=0
  - `busy`=0, `done`=0
  - all address and data outputs 0

## Timing
- All state and counters are registered. `im_we`, `ld_ready`, `dump_valid` and `cpu_clk_en` decode from the registered state and counters.
- `start` sampled at edge N → LOAD at N+1, so `ld_ready` is first high in cycle N+1.
- Last load handshake at edge M → CPURST for edges M+1 and M+2 → first enabled core edge at M+3.
- `dump_valid` rises the cycle after the last enabled core edge.
- Dump throughput: 1 word/cycle with `dump_ready` held high, 32+DUMP_WORDS words in total.

## Configuration
- `RUN_TRACE_EN` defined:
  - Adds inputs `cpu_pc` 32 and `cpu_instr` 32, and outputs `tr_valid` 1, `tr_pc` 32, `tr_instr` 32.
  - `tr_valid`=1 in every enabled RUN cycle, with PC/instruction registered one cycle later. No backpressure.
  - Reset value of all trace outputs: 0.
- Undefined: the trace ports are absent and behaviour is otherwise identical.

## Structure
- Shared package `mips_ctrl_pkg`: state enum, `RF_WORDS`=32, `CPURST_CYCLES`=2, status encodings.
- One sub-module `dump_seq`: an index counter plus valid/ready holding, instantiated once and reused for the RF and DM phases with a select.

## Test plan
- Load 3 words (0x20080005, 0x21090003, 0xAC090000, last on the 3rd), `run_cycles`=4:
  - `im_addr` 0,1,2 written
  - exactly 4 core enables
  - dump word 9 = 0x8, DM word 0 = 0x8
  - `dump_last` on word 40.
- `run_cycles`=0 → no `cpu_clk_en` pulse. Dump begins 1 cycle after CPURST ends.
- Backpressure: `dump_ready` toggled every other cycle → `dump_data`/`rf_raddr` are stable while stalled and 41 words are delivered in order.
- Load 1025 words with `ld_last` never set → 1024 writes, `ld_ready` drops after address 0x3FF, then CPURST.
- `start` during RUN is ignored. Async `rst` low mid-DUMP_RF → IDLE immediately, `dump_valid`=0, `cpu_rst`=1.
- With `RUN_TRACE_EN`, `run_cycles`=3 → 3 `tr_valid` pulses carrying PCs 0x3000, 0x3004, 0x3008.
